intack_sequencer: RTL and testbench

- CPU-side counterpart of the interrupt controller. Samples intr/irq at instruction boundaries and latches the vector.
- Issues a single-cycle inta acknowledge, then presents the vector to the core through a req/taken handshake.
- Acts as a data_m bus initiator to write non-specific or specific EOI commands to the controller's command port.
- Sits between the PIC and the core microcode/interrupt logic.

---
 rtl/intack_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_intack_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intack_sequencer.sv
// rtl/intack_sequencer.sv - CPU-side interrupt acknowledge and EOI issue sequencer
//
// Purpose:
//   Samples the interrupt controller's intr/irq at instruction boundaries,
//   latches the vector, issues a one-cycle inta and hands the vector to the
//   core through int_req/int_taken. Independently, it writes non-specific or
//   specific EOI command bytes to the controller's command port as a bus
//   initiator, with an acknowledge timeout.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   core_int_enable, intr, irq[7:0]    sampling permit, request, vector in
//   inta                               one-cycle acknowledge strobe
//   int_req, int_vector[7:0], int_taken  vector handshake with the core
//   eoi_req, eoi_specific, eoi_level[2:0]  EOI request and command select
//   eoi_busy, eoi_done, eoi_error      EOI status (done/error are pulses)
//   data_m_*                           bus initiator write port, data_m_ack in

module intack_sequencer #(
    parameter logic [18:0] PIC_ADDR       = 19'h00010,
    parameter int          HOLDOFF_CYCLES = 1,
    parameter int          ACK_TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        core_int_enable,
    input  logic        intr,
    input  logic [7:0]  irq,
    output logic        inta,
    output logic        int_req,
    output logic [7:0]  int_vector,
    input  logic        int_taken,
    input  logic        eoi_req,
    input  logic        eoi_specific,
    input  logic [2:0]  eoi_level,
    output logic        eoi_busy,
    output logic        eoi_done,
    output logic        eoi_error,
    output logic [18:0] data_m_addr,
    output logic [15:0] data_m_data_out,
    output logic [1:0]  data_m_bytesel,
    output logic        data_m_wr_en,
    output logic        data_m_access,
    input  logic        data_m_ack
);

    localparam logic [2:0] HOLD_LOAD    = 3'(HOLDOFF_CYCLES);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        A_IDLE,
        A_ACK,
        A_PRESENT,
        A_HOLD
    } a_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_STROBE,
        E_WAIT
    } e_state_t;

    a_state_t    a_state, a_next;
    logic [2:0]  hold_cnt, hold_next;
    logic [7:0]  vec_next;

    e_state_t    e_state, e_next;
    logic [7:0]  to_cnt, to_next;
    logic [7:0]  cmd, cmd_next;
    logic        done_next, error_next;

    // ------------------------------------------------------------------
    // Acknowledge FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_state    <= A_IDLE;
            hold_cnt   <= 3'd0;
            int_vector <= 8'h00;
        end else begin
            a_state    <= a_next;
            hold_cnt   <= hold_next;
            int_vector <= vec_next;
        end
    end

    always_comb begin
        a_next    = a_state;
        hold_next = hold_cnt;
        vec_next  = int_vector;
        inta      = 1'b0;
        int_req   = 1'b0;
        case (a_state)
            A_IDLE: begin
                // The controller zeroes irq while inta is high, so the vector
                // must be captured on the sampling edge, ahead of inta.
                if (intr && core_int_enable) begin
                    vec_next = irq;
                    a_next   = A_ACK;
                end
            end
            A_ACK: begin
                inta   = 1'b1;
                a_next = A_PRESENT;
            end
            A_PRESENT: begin
                int_req = 1'b1;
                if (int_taken) begin
                    hold_next = HOLD_LOAD;
                    a_next    = A_HOLD;
                end
            end
            A_HOLD: begin
                // intr is ignored here so the controller's in-service update
                // settles before the next sample; one cycle per count.
                hold_next = hold_cnt - 3'd1;
                if (hold_cnt <= 3'd1) begin
                    hold_next = 3'd0;
                    a_next    = A_IDLE;
                end
            end
            default: a_next = A_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // EOI issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_state   <= E_IDLE;
            to_cnt    <= 8'd0;
            cmd       <= 8'h00;
            eoi_done  <= 1'b0;
            eoi_error <= 1'b0;
        end else begin
            e_state   <= e_next;
            to_cnt    <= to_next;
            cmd       <= cmd_next;
            eoi_done  <= done_next;
            eoi_error <= error_next;
        end
    end

    always_comb begin
        e_next        = e_state;
        to_next       = to_cnt;
        cmd_next      = cmd;
        done_next     = 1'b0;
        error_next    = 1'b0;
        data_m_access = 1'b0;
        case (e_state)
            E_IDLE: begin
                if (eoi_req) begin
                    cmd_next = eoi_specific ? {3'b011, 2'b00, eoi_level} : 8'h20;
                    e_next   = E_STROBE;
                end
            end
            E_STROBE: begin
                // The controller acts on every access cycle, so the strobe
                // must never last more than this single state.
                data_m_access = 1'b1;
                to_next       = TIMEOUT_LOAD;
                e_next        = E_WAIT;
            end
            E_WAIT: begin
                if (data_m_ack) begin
                    done_next = 1'b1;
                    e_next    = E_IDLE;
                end else if (to_cnt <= 8'd1) begin
                    error_next = 1'b1;
                    to_next    = 8'd0;
                    e_next     = E_IDLE;
                end else begin
                    to_next = to_cnt - 8'd1;
                end
            end
            default: e_next = E_IDLE;
        endcase
    end

    // Bus qualifiers are held for the whole transaction and derived from
    // state so that reset removes them without waiting for a clock.
    assign eoi_busy        = (e_state != E_IDLE);
    assign data_m_wr_en    = eoi_busy;
    assign data_m_bytesel  = eoi_busy ? 2'b01 : 2'b00;
    assign data_m_addr     = eoi_busy ? PIC_ADDR : 19'h00000;
    assign data_m_data_out = eoi_busy ? {8'h00, cmd} : 16'h0000;

endmodule

// File: tb/tb_intack_sequencer.sv
// tb/tb_intack_sequencer.sv - self-checking bench for intack_sequencer

module tb_intack_sequencer;

    localparam logic [18:0] PIC_ADDR    = 19'h00010;
    localparam int          ACK_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_int_enable;
    logic        intr;
    logic [7:0]  irq;
    logic        inta;
    logic        int_req;
    logic [7:0]  int_vector;
    logic        int_taken;
    logic        eoi_req;
    logic        eoi_specific;
    logic [2:0]  eoi_level;
    logic        eoi_busy;
    logic        eoi_done;
    logic        eoi_error;
    logic [18:0] data_m_addr;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_access;
    logic        data_m_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intack_sequencer #(
        .PIC_ADDR(PIC_ADDR),
        .HOLDOFF_CYCLES(1),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .core_int_enable(core_int_enable),
        .intr(intr),
        .irq(irq),
        .inta(inta),
        .int_req(int_req),
        .int_vector(int_vector),
        .int_taken(int_taken),
        .eoi_req(eoi_req),
        .eoi_specific(eoi_specific),
        .eoi_level(eoi_level),
        .eoi_busy(eoi_busy),
        .eoi_done(eoi_done),
        .eoi_error(eoi_error),
        .data_m_addr(data_m_addr),
        .data_m_data_out(data_m_data_out),
        .data_m_bytesel(data_m_bytesel),
        .data_m_wr_en(data_m_wr_en),
        .data_m_access(data_m_access),
        .data_m_ack(data_m_ack)
    );

    // Small controller model: vector base 0x08, fixed priority (0 highest).
    logic [7:0] irr, isr, raise;
    logic       model_clr;
    int         eoi_writes;
    logic [3:0] pend_idx, isr_idx;

    function automatic logic [3:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 4'(i);
        return 4'd8;
    endfunction

    always_comb begin
        pend_idx = lowest(irr);
        isr_idx  = lowest(isr);
        intr     = (pend_idx < isr_idx);
        irq      = (intr && !inta) ? (8'h08 + {4'h0, pend_idx}) : 8'h00;
    end

    always @(posedge clk) begin : pic_model
        logic [7:0] irr_n, isr_n;
        if (model_clr) begin
            irr        <= 8'h00;
            isr        <= 8'h00;
            eoi_writes <= 0;
        end else begin
            irr_n = irr | raise;
            isr_n = isr;
            if (data_m_access && data_m_wr_en) begin
                eoi_writes <= eoi_writes + 1;
                if (data_m_data_out == 16'h0020) begin
                    if (isr_idx < 4'd8) isr_n[isr_idx[2:0]] = 1'b0;
                end else if (data_m_data_out[7:3] == 5'b01100) begin
                    isr_n[data_m_data_out[2:0]] = 1'b0;
                end
            end
            if (inta && pend_idx < 4'd8) begin
                irr_n[pend_idx[2:0]] = 1'b0;
                isr_n[pend_idx[2:0]] = 1'b1;
            end
            irr <= irr_n;
            isr <= isr_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({inta, int_req, int_vector, eoi_busy, eoi_done, eoi_error,
                    data_m_addr, data_m_data_out, data_m_bytesel, data_m_wr_en, data_m_access});
    endfunction

    typedef struct {
        logic        spec;
        logic [2:0]  lvl;
        int          ack_delay;   // wait cycles until ack; 0 = never acked
        logic [15:0] exp_data;
        logic        ack_early;   // ack driven during strobe (must be ignored)
    } eoi_vec_t;

    task automatic run_eoi(input eoi_vec_t v, input string tag);
        int n;
        int w0;
        w0 = eoi_writes;
        eoi_specific = v.spec;
        eoi_level    = v.lvl;
        eoi_req      = 1'b1;
        tick();
        eoi_req    = 1'b0;
        data_m_ack = v.ack_early;
        chk({tag, "_strobe"}, {data_m_access, data_m_wr_en, data_m_bytesel, eoi_busy}, 5'b11011);
        chk({tag, "_addr"}, 64'(data_m_addr), 64'(PIC_ADDR));
        chk({tag, "_data"}, 64'(data_m_data_out), 64'(v.exp_data));
        tick();
        data_m_ack = 1'b0;
        chk({tag, "_wait"}, {data_m_access, data_m_wr_en, eoi_busy, eoi_done}, 4'b0110);
        chk({tag, "_data_held"}, 64'(data_m_data_out), 64'(v.exp_data));
        if (v.ack_delay > 0) begin
            for (int i = 1; i < v.ack_delay; i++) tick();
            chk({tag, "_busy_before_ack"}, {eoi_busy, eoi_error}, 2'b10);
            data_m_ack = 1'b1;
            tick();
            data_m_ack = 1'b0;
            chk({tag, "_done"}, {eoi_done, eoi_error, eoi_busy}, 3'b100);
            tick();
            chk({tag, "_done_pulse"}, {eoi_done, eoi_busy}, 2'b00);
        end else begin
            n = 0;
            while (!eoi_error && n < 300) begin
                tick();
                n++;
            end
            chk({tag, "_timeout_cycles"}, 64'(n), 64'(ACK_TIMEOUT));
            chk({tag, "_error"}, {eoi_error, eoi_busy, eoi_done}, 3'b100);
            tick();
            chk({tag, "_error_pulse"}, 64'(eoi_error), 64'd0);
        end
        chk({tag, "_single_write"}, 64'(eoi_writes - w0), 64'd1);
    endtask

    task automatic take_vector();
        int_taken = 1'b1;
        tick();
        int_taken = 1'b0;
    endtask

    eoi_vec_t tbl[5];
    eoi_vec_t nse;

    initial begin
        tbl[0] = '{spec: 1'b0, lvl: 3'd0, ack_delay: 1,  exp_data: 16'h0020, ack_early: 1'b0};
        tbl[1] = '{spec: 1'b1, lvl: 3'd5, ack_delay: 0,  exp_data: 16'h0065, ack_early: 1'b0};
        tbl[2] = '{spec: 1'b1, lvl: 3'd3, ack_delay: 4,  exp_data: 16'h0063, ack_early: 1'b1};
        tbl[3] = '{spec: 1'b0, lvl: 3'd7, ack_delay: 2,  exp_data: 16'h0020, ack_early: 1'b0};
        tbl[4] = '{spec: 1'b1, lvl: 3'd0, ack_delay: ACK_TIMEOUT, exp_data: 16'h0060, ack_early: 1'b0};
        nse    = tbl[0];

        reset_n = 1'b0; model_clr = 1'b1; raise = 8'h00;
        core_int_enable = 1'b0; int_taken = 1'b0;
        eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; data_m_ack = 1'b0;
        tick(); tick();
        chk("reset_outputs", all_outs(), 64'd0);
        reset_n = 1'b1; model_clr = 1'b0;
        tick();
        chk("post_reset_idle", all_outs(), 64'd0);

        // IRQ3 with sampling permitted
        core_int_enable = 1'b1;
        raise = 8'h08;
        tick();
        raise = 8'h00;
        chk("irq3_not_yet", 64'(inta), 64'd0);
        tick();
        chk("irq3_inta", {inta, int_req, int_vector}, {2'b10, 8'h0B});
        tick();
        chk("irq3_present", {inta, int_req, int_vector}, {2'b01, 8'h0B});
        tick();
        chk("irq3_held", {inta, int_req, int_vector}, {2'b01, 8'h0B});
        take_vector();
        chk("irq3_req_low", {inta, int_req}, 2'b00);
        tick();
        chk("isr_before_eoi", 64'(isr), 64'h08);
        run_eoi(nse, "eoi_irq3");
        chk("isr_after_eoi", 64'(isr), 64'h00);

        // EOI command encodings and ack timing
        foreach (tbl[i]) run_eoi(tbl[i], $sformatf("eoi_tbl%0d", i));

        // eoi_req while busy is dropped
        eoi_req = 1'b1;
        tick();
        chk("busy_strobe", 64'(data_m_access), 64'd1);
        tick();
        chk("busy_drop_wait", {data_m_access, eoi_busy}, 2'b01);
        eoi_req = 1'b0;
        data_m_ack = 1'b1;
        tick();
        data_m_ack = 1'b0;
        chk("busy_drop_done", {eoi_done, eoi_busy}, 2'b10);
        tick();
        chk("busy_drop_no_requeue", {eoi_busy, data_m_access}, 2'b00);

        // sampling gated by core_int_enable
        core_int_enable = 1'b0;
        raise = 8'h10;
        tick();
        raise = 8'h00;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (inta) seen++;
            end
            chk("gated_no_inta", 64'(seen), 64'd0);
        end
        core_int_enable = 1'b1;
        tick();
        chk("enable_inta", {inta, int_vector}, {1'b1, 8'h0C});
        tick();
        chk("enable_present", {inta, int_req, int_vector}, {2'b01, 8'h0C});
        take_vector();
        tick();
        run_eoi(nse, "eoi_irq4");

        // IRQ0 and IRQ1 pending together
        raise = 8'h03;
        tick();
        raise = 8'h00;
        tick();
        chk("irq0_inta", {inta, int_vector}, {1'b1, 8'h08});
        tick();
        chk("irq0_present", {int_req, int_vector}, {1'b1, 8'h08});
        run_eoi(nse, "eoi_irq0");
        chk("irq0_still_present", {inta, int_req, int_vector}, {2'b01, 8'h08});
        take_vector();
        chk("irq0_hold", {inta, int_req}, 2'b00);
        tick();
        chk("irq0_no_dup", 64'(inta), 64'd0);
        tick();
        chk("irq1_inta", {inta, int_vector}, {1'b1, 8'h09});
        tick();
        chk("irq1_present", {int_req, int_vector}, {1'b1, 8'h09});
        take_vector();
        tick();
        run_eoi(nse, "eoi_irq1");
        chk("isr_clean", 64'(isr), 64'h00);

        // reset during E_WAIT
        eoi_specific = 1'b0;
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        tick();
        chk("wait_before_reset", {eoi_busy, data_m_wr_en}, 2'b11);
        #2 reset_n = 1'b0;
        #1 chk("reset_in_wait", all_outs(), 64'd0);
        tick();
        reset_n = 1'b1;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < ACK_TIMEOUT + 4; i++) begin
                data_m_ack = (i == 1);
                tick();
                if (eoi_done || eoi_error || eoi_busy) stray++;
            end
            data_m_ack = 1'b0;
            chk("no_retry_after_reset", 64'(stray), 64'd0);
        end

        // reset while inta is high, then a fresh sequence
        raise = 8'h04;
        tick();
        raise = 8'h00;
        tick();
        chk("inta_before_reset", {inta, int_vector}, {1'b1, 8'h0A});
        #2 reset_n = 1'b0;
        #1 chk("reset_in_ack", all_outs(), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("fresh_inta", {inta, int_vector}, {1'b1, 8'h0A});
        tick();
        chk("fresh_present", {int_req, int_vector}, {1'b1, 8'h0A});
        take_vector();
        tick();
        run_eoi(nse, "eoi_fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
